memory_arbiter: RTL and testbench

//  Shares one main-memory block port between the instruction cache and the data cache of the
//  RV32IM pipeline. Replaces the separate instruction_memory/data_memory paths with one backing

---
 rtl/memory_arbiter.sv | 147 ++++++++++++++
 tb/tb_memory_arbiter.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_arbiter.sv
// Shares one main-memory block port between the I-cache and D-cache with a registered request path.
// Optional MEM_ARB_ROUND_ROBIN_EN: alternate grants on conflict instead of fixed D-over-I priority.
module memory_arbiter #(
    parameter int ADDR_WIDTH = 28,
    parameter int DATA_WIDTH = 128
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  I_READ,
    input  logic [ADDR_WIDTH-1:0] I_ADDRESS,
    output logic [DATA_WIDTH-1:0] I_READDATA,
    output logic                  I_BUSYWAIT,
    input  logic                  D_READ,
    input  logic                  D_WRITE,
    input  logic [ADDR_WIDTH-1:0] D_ADDRESS,
    input  logic [DATA_WIDTH-1:0] D_WRITEDATA,
    output logic [DATA_WIDTH-1:0] D_READDATA,
    output logic                  D_BUSYWAIT,
    output logic                  MEM_READ,
    output logic                  MEM_WRITE,
    output logic [ADDR_WIDTH-1:0] MEM_ADDRESS,
    output logic [DATA_WIDTH-1:0] MEM_WRITEDATA,
    input  logic [DATA_WIDTH-1:0] MEM_READDATA,
    input  logic                  MEM_BUSYWAIT
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SERVE,
        S_RESP
    } state_t;

    typedef enum logic {
        GRANT_I = 1'b0,
        GRANT_D = 1'b1
    } grant_t;

    state_t                state_q, state_d;
    grant_t                grant_q, grant_d;
    grant_t                last_grant_q, last_grant_d;
    logic                  first_q, first_d;
    logic                  mem_read_q, mem_read_d;
    logic                  mem_write_q, mem_write_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

    logic req_i;
    logic req_d;
    logic pick_d;

    always_comb begin
        req_i = I_READ;
        req_d = D_READ | D_WRITE;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        pick_d = req_d & (~req_i | (last_grant_q == GRANT_I));
`else
        pick_d = req_d;
`endif

        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        first_d      = first_q;
        mem_read_d   = mem_read_q;
        mem_write_d  = mem_write_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        rdata_d      = rdata_q;

        case (state_q)
            S_IDLE: begin
                if (req_i | req_d) begin
                    state_d = S_SERVE;
                    first_d = 1'b1;
                    if (pick_d) begin
                        // A simultaneous read+write from the D-cache is a write-back.
                        grant_d      = GRANT_D;
                        last_grant_d = GRANT_D;
                        mem_addr_d   = D_ADDRESS;
                        mem_wdata_d  = D_WRITEDATA;
                        mem_write_d  = D_WRITE;
                        mem_read_d   = ~D_WRITE;
                    end else begin
                        grant_d      = GRANT_I;
                        last_grant_d = GRANT_I;
                        mem_addr_d   = I_ADDRESS;
                        mem_write_d  = 1'b0;
                        mem_read_d   = 1'b1;
                    end
                end
            end
            S_SERVE: begin
                first_d = 1'b0;
                // Memory asserts busy combinationally off our strobe, so the first cycle is blind.
                if (!first_q && !MEM_BUSYWAIT) begin
                    if (mem_read_q) begin
                        rdata_d = MEM_READDATA;
                    end
                    mem_read_d  = 1'b0;
                    mem_write_d = 1'b0;
                    state_d     = S_RESP;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q      <= S_IDLE;
            grant_q      <= GRANT_I;
            last_grant_q <= GRANT_I;
            first_q      <= 1'b0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            rdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            first_q      <= first_d;
            mem_read_q   <= mem_read_d;
            mem_write_q  <= mem_write_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            rdata_q      <= rdata_d;
        end
    end

    assign I_BUSYWAIT    = I_READ & ~((state_q == S_RESP) & (grant_q == GRANT_I));
    assign D_BUSYWAIT    = (D_READ | D_WRITE) & ~((state_q == S_RESP) & (grant_q == GRANT_D));
    assign I_READDATA    = rdata_q;
    assign D_READDATA    = rdata_q;
    assign MEM_READ      = mem_read_q;
    assign MEM_WRITE     = mem_write_q;
    assign MEM_ADDRESS   = mem_addr_q;
    assign MEM_WRITEDATA = mem_wdata_q;

endmodule

// File: tb/tb_memory_arbiter.sv
// Scoreboard bench for memory_arbiter: directed cache requests, a latency-programmable memory model,
// and a negedge monitor that checks the memory side and each completion against queued expectations.
module tb_memory_arbiter;

    logic         CLK;
    logic         RESET;
    logic         I_READ;
    logic [27:0]  I_ADDRESS;
    logic [127:0] I_READDATA;
    logic         I_BUSYWAIT;
    logic         D_READ;
    logic         D_WRITE;
    logic [27:0]  D_ADDRESS;
    logic [127:0] D_WRITEDATA;
    logic [127:0] D_READDATA;
    logic         D_BUSYWAIT;
    logic         MEM_READ;
    logic         MEM_WRITE;
    logic [27:0]  MEM_ADDRESS;
    logic [127:0] MEM_WRITEDATA;
    logic [127:0] MEM_READDATA;
    logic         MEM_BUSYWAIT;

    memory_arbiter #(
        .ADDR_WIDTH(28),
        .DATA_WIDTH(128)
    ) dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .I_READ       (I_READ),
        .I_ADDRESS    (I_ADDRESS),
        .I_READDATA   (I_READDATA),
        .I_BUSYWAIT   (I_BUSYWAIT),
        .D_READ       (D_READ),
        .D_WRITE      (D_WRITE),
        .D_ADDRESS    (D_ADDRESS),
        .D_WRITEDATA  (D_WRITEDATA),
        .D_READDATA   (D_READDATA),
        .D_BUSYWAIT   (D_BUSYWAIT),
        .MEM_READ     (MEM_READ),
        .MEM_WRITE    (MEM_WRITE),
        .MEM_ADDRESS  (MEM_ADDRESS),
        .MEM_WRITEDATA(MEM_WRITEDATA),
        .MEM_READDATA (MEM_READDATA),
        .MEM_BUSYWAIT (MEM_BUSYWAIT)
    );

    typedef struct {
        bit           is_d;
        bit           wr;
        logic [27:0]  addr;
        logic [127:0] wdata;
        logic [127:0] rdata;
    } exp_t;

    exp_t         sb[$];
    int           checks = 0;
    int           errors = 0;
    int           lat = 2;
    int           cnt = 0;
    logic [127:0] mem_arr[32];

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] pat(input int unsigned idx);
        return {4{32'hC0DE0000 | 32'(idx)}};
    endfunction

    // Memory model: busy for `lat` cycles after a strobe appears, write committed when busy drops.
    initial begin
        for (int unsigned i = 0; i < 32; i++) mem_arr[i] = pat(i);
        mem_arr[4]   = {16{8'hA5}};
        MEM_BUSYWAIT = 1'b0;
        MEM_READDATA = '0;
        forever begin
            @(posedge CLK);
            #1;
            if (MEM_READ || MEM_WRITE) begin
                if (cnt < lat) begin
                    MEM_BUSYWAIT = 1'b1;
                    cnt++;
                end else begin
                    MEM_BUSYWAIT = 1'b0;
                    if (MEM_WRITE) mem_arr[MEM_ADDRESS[4:0]] = MEM_WRITEDATA;
                end
            end else begin
                MEM_BUSYWAIT = 1'b0;
                cnt = 0;
            end
            MEM_READDATA = mem_arr[MEM_ADDRESS[4:0]];
        end
    end

    task automatic complete(input bit is_d, input logic [127:0] data);
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL completion_unexpected: side %0d completed, expected no completion", is_d);
        end else begin
            e = sb.pop_front();
            check(is_d ? "d_completion_side" : "i_completion_side", 128'(is_d), 128'(e.is_d));
            check(is_d ? "d_readdata" : "i_readdata", data, e.rdata);
        end
    endtask

    // Monitor: sampled on the falling edge, away from the active edge and stimulus changes.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge CLK);
            if (MEM_READ || MEM_WRITE) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL mem_unexpected: strobe at addr %h, expected none", MEM_ADDRESS);
                end else begin
                    e = sb[0];
                    check("mem_op", 128'({MEM_WRITE, MEM_READ}), 128'({e.wr, !e.wr}));
                    check("mem_addr", 128'(MEM_ADDRESS), 128'(e.addr));
                    if (e.wr) check("mem_wdata", MEM_WRITEDATA, e.wdata);
                end
            end
            if (I_READ && !I_BUSYWAIT) complete(1'b0, I_READDATA);
            if ((D_READ || D_WRITE) && !D_BUSYWAIT) complete(1'b1, D_READDATA);
            if (!I_READ) check("i_busy_idle", 128'(I_BUSYWAIT), 128'(0));
            if (!(D_READ || D_WRITE)) check("d_busy_idle", 128'(D_BUSYWAIT), 128'(0));
        end
    end

    task automatic push(input bit is_d, input bit wr, input logic [27:0] a,
                        input logic [127:0] wd, input logic [127:0] rd);
        exp_t e;
        e.is_d  = is_d;
        e.wr    = wr;
        e.addr  = a;
        e.wdata = wd;
        e.rdata = rd;
        sb.push_back(e);
    endtask

    task automatic drive_i(input logic [27:0] a);
        bit done = 0;
        I_ADDRESS = a;
        I_READ    = 1'b1;
        for (int n = 0; n < 100; n++) begin
            @(posedge CLK);
            #1;
            if (!I_BUSYWAIT) begin
                done = 1;
                break;
            end
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL i_timeout: busywait still 1 after 100 cycles, expected 0");
        end else begin
            @(posedge CLK);
            #1;
            check("i_busy_after_resp", 128'(I_BUSYWAIT), 128'(1));
        end
        I_READ = 1'b0;
    endtask

    task automatic drive_d(input logic rd, input logic wr, input logic [27:0] a, input logic [127:0] wd);
        bit done = 0;
        D_ADDRESS   = a;
        D_WRITEDATA = wd;
        D_READ      = rd;
        D_WRITE     = wr;
        for (int n = 0; n < 100; n++) begin
            @(posedge CLK);
            #1;
            if (!D_BUSYWAIT) begin
                done = 1;
                break;
            end
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL d_timeout: busywait still 1 after 100 cycles, expected 0");
        end else begin
            @(posedge CLK);
            #1;
            check("d_busy_after_resp", 128'(D_BUSYWAIT), 128'(1));
        end
        D_READ  = 1'b0;
        D_WRITE = 1'b0;
    endtask

    task automatic settle();
        @(negedge CLK);
        #1;
    endtask

    task automatic conflict();
`ifdef MEM_ARB_ROUND_ROBIN_EN
        push(1'b0, 1'b0, 28'h8, '0, pat(8));
        push(1'b1, 1'b0, 28'hC, '0, pat(12));
`else
        push(1'b1, 1'b0, 28'hC, '0, pat(12));
        push(1'b0, 1'b0, 28'h8, '0, pat(8));
`endif
        fork
            drive_i(28'h8);
            drive_d(1'b1, 1'b0, 28'hC, '0);
        join
        settle();
    endtask

    initial begin : stim
        logic [127:0] held;
        RESET       = 1'b1;
        I_READ      = 1'b0;
        I_ADDRESS   = '0;
        D_READ      = 1'b0;
        D_WRITE     = 1'b0;
        D_ADDRESS   = '0;
        D_WRITEDATA = '0;
        repeat (3) @(posedge CLK);
        #1;
        RESET = 1'b0;
        settle();
        check("rst_mem_strobes", 128'({MEM_WRITE, MEM_READ}), 128'(0));
        check("rst_mem_addr", 128'(MEM_ADDRESS), 128'(0));
        check("rst_mem_wdata", MEM_WRITEDATA, '0);
        check("rst_i_readdata", I_READDATA, '0);
        check("rst_d_readdata", D_READDATA, '0);

        // I read alone, 5-cycle memory busy
        lat = 5;
        push(1'b0, 1'b0, 28'h4, '0, {16{8'hA5}});
        fork
            drive_i(28'h4);
            begin
                @(posedge CLK);
                #2;
                check("t1_mem_read_after_sample", 128'({MEM_WRITE, MEM_READ}), 128'(2'b01));
            end
        join
        settle();

        // D write-back: readdata register must keep the previous block
        lat = 2;
        push(1'b1, 1'b1, 28'h10, 128'h1234, {16{8'hA5}});
        drive_d(1'b0, 1'b1, 28'h10, 128'h1234);
        settle();
        push(1'b1, 1'b0, 28'h10, '0, 128'h1234);
        drive_d(1'b1, 1'b0, 28'h10, '0);
        settle();

        // Two simultaneous conflicts: fixed priority D,I or round-robin I,D
        conflict();
        conflict();

        // D_READ and D_WRITE together act as a write
`ifdef MEM_ARB_ROUND_ROBIN_EN
        held = pat(12);
`else
        held = pat(8);
`endif
        push(1'b1, 1'b1, 28'h14, 128'h5555, held);
        drive_d(1'b1, 1'b1, 28'h14, 128'h5555);
        settle();

        // Reset in the 3rd SERVE cycle aborts, then the held request is re-granted
        lat = 5;
        push(1'b0, 1'b0, 28'h18, '0, pat(24));
        fork
            drive_i(28'h18);
            begin
                repeat (3) @(posedge CLK);
                #1;
                RESET = 1'b1;
                @(posedge CLK);
                #1;
                check("abort_mem_strobes", 128'({MEM_WRITE, MEM_READ}), 128'(0));
                check("abort_readdata", I_READDATA, '0);
                check("abort_i_busy", 128'(I_BUSYWAIT), 128'(1));
                RESET = 1'b0;
                @(posedge CLK);
                #2;
                check("abort_regrant", 128'({MEM_WRITE, MEM_READ}), 128'(2'b01));
            end
        join
        settle();

        repeat (4) @(negedge CLK);
        check("scoreboard_drained", 128'(sb.size()), 128'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
